// File: rtl/axi_store_buffer_pkg.sv
// -----------------------------------------------------------------------------
// axi_store_buffer_pkg
// Shared types for the posted-write store buffer: drain FSM state encodings,
// default bus widths and the packed layout of one buffered store entry.
// Optional feature macro used by the block: STORE_BUF_FWD_EN.
// -----------------------------------------------------------------------------
package axi_store_buffer_pkg;

    localparam int unsigned SB_DATA_WIDTH = 32;
    localparam int unsigned SB_ADDR_WIDTH = 32;
    localparam int unsigned SB_ID_WIDTH   = 6;
    localparam int unsigned SB_STRB_WIDTH = SB_DATA_WIDTH / 8;
    localparam int unsigned SB_SIZE_WIDTH = 3;

    // Drain FSM: present head to the master, then wait for its B response.
    typedef enum logic [0:0] {
        SB_ISSUE     = 1'b0,
        SB_WAIT_RESP = 1'b1
    } sb_state_e;

    // One posted store as held in the buffer.
    typedef struct packed {
        logic [SB_ADDR_WIDTH-1:0] addr;
        logic [SB_DATA_WIDTH-1:0] data;
        logic [SB_STRB_WIDTH-1:0] mask;
        logic [SB_SIZE_WIDTH-1:0] size;
    } sb_entry_t;

endpackage

// File: rtl/axi_store_buffer_if.sv
// -----------------------------------------------------------------------------
// axi_store_buffer_if
// Bundles the core store/load-check port and the write-master request port of
// the store buffer.
//   slave  : the store buffer (takes stores and master status, drives requests)
//   master : the environment (core + AXI write master)
// With STORE_BUF_FWD_EN defined the bundle also carries fwd_valid/fwd_data.
// -----------------------------------------------------------------------------
interface axi_store_buffer_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 6,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
    // core store port
    logic                  st_req;
    logic [ADDR_WIDTH-1:0] st_addr;
    logic [DATA_WIDTH-1:0] st_wdata;
    logic [STRB_WIDTH-1:0] st_wmask;
    logic [2:0]            st_size;
    logic                  st_ready;
    // load hazard check
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic                  ld_hit;
    logic                  sb_empty;
    // write master request/response
    logic                  wen;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wmask;
    logic [2:0]            awsize;
    logic [ID_WIDTH-1:0]   awid;
    logic                  data_resp;
    logic                  waddr_ok;
    logic                  wdata_ok;
    logic                  writing;
`ifdef STORE_BUF_FWD_EN
    logic                  fwd_valid;
    logic [DATA_WIDTH-1:0] fwd_data;

    modport slave (
        input  st_req, st_addr, st_wdata, st_wmask, st_size, ld_addr,
               waddr_ok, wdata_ok, writing,
        output st_ready, ld_hit, sb_empty, wen, awaddr, wdata, wmask,
               awsize, awid, data_resp, fwd_valid, fwd_data
    );
    modport master (
        output st_req, st_addr, st_wdata, st_wmask, st_size, ld_addr,
               waddr_ok, wdata_ok, writing,
        input  st_ready, ld_hit, sb_empty, wen, awaddr, wdata, wmask,
               awsize, awid, data_resp, fwd_valid, fwd_data
    );
`else
    modport slave (
        input  st_req, st_addr, st_wdata, st_wmask, st_size, ld_addr,
               waddr_ok, wdata_ok, writing,
        output st_ready, ld_hit, sb_empty, wen, awaddr, wdata, wmask,
               awsize, awid, data_resp
    );
    modport master (
        output st_req, st_addr, st_wdata, st_wmask, st_size, ld_addr,
               waddr_ok, wdata_ok, writing,
        input  st_ready, ld_hit, sb_empty, wen, awaddr, wdata, wmask,
               awsize, awid, data_resp
    );
`endif
endinterface

// File: rtl/axi_store_buffer_match.sv
// -----------------------------------------------------------------------------
// axi_store_buffer_match
// Parallel word-address comparators of a load address against every valid
// store-buffer entry, with a youngest-match priority select.
//   ld_word_i   : word part of the load address
//   word_addr_i : word address of each buffer slot
//   count_i     : number of valid entries, starting at rd_ptr_i (oldest)
//   hit_c       : some valid entry matches (combinational)
// STORE_BUF_FWD_EN adds data_i/full_mask_i inputs and fwd_valid_c/fwd_data_c
// outputs carrying the youngest match's data when its strobes are all set.
// -----------------------------------------------------------------------------
module axi_store_buffer_match #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned PTR_W      = 2,
    parameter int unsigned WORD_W     = 30,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [WORD_W-1:0]     ld_word_i,
    input  logic [WORD_W-1:0]     word_addr_i [DEPTH],
    input  logic [PTR_W:0]        count_i,
    input  logic [PTR_W-1:0]      rd_ptr_i,
`ifdef STORE_BUF_FWD_EN
    input  logic [DATA_WIDTH-1:0] data_i [DEPTH],
    input  logic [DEPTH-1:0]      full_mask_i,
    output logic                  fwd_valid_c,
    output logic [DATA_WIDTH-1:0] fwd_data_c,
`endif
    output logic                  hit_c
);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        hit_c = 1'b0;
        idx   = '0;
`ifdef STORE_BUF_FWD_EN
        fwd_valid_c = 1'b0;
        fwd_data_c  = '0;
`endif
        for (int unsigned age = 0; age < DEPTH; age++) begin
            idx = rd_ptr_i + PTR_W'(age);
            if ((CNT_W'(age) < count_i) && (word_addr_i[idx] == ld_word_i)) begin
                hit_c = 1'b1;
`ifdef STORE_BUF_FWD_EN
                fwd_valid_c = full_mask_i[idx];
                fwd_data_c  = data_i[idx];
`endif
            end
        end
    end

endmodule

// File: rtl/axi_store_buffer.sv
// -----------------------------------------------------------------------------
// axi_store_buffer
// Posted-write buffer between the core store port and the AXI write master.
// Stores are accepted in one cycle into a DEPTH-entry circular FIFO and drained
// one at a time; each entry is held until its B response retires it.
//   ACLK, ARESETn : clock, asynchronous active-low reset
//   bus (slave)   : st_* store port, ld_addr/ld_hit hazard check, sb_empty,
//                   wen/awaddr/wdata/wmask/awsize/awid/data_resp to the master,
//                   waddr_ok/wdata_ok/writing from the master
// Optional: STORE_BUF_FWD_EN adds store-to-load forwarding (fwd_valid/fwd_data).
// Entry fields are laid out by axi_store_buffer_pkg; width parameters default
// to the package widths and must be kept equal to them.
// -----------------------------------------------------------------------------
module axi_store_buffer
    import axi_store_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SB_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = SB_ADDR_WIDTH,
    parameter int unsigned ID_WIDTH   = SB_ID_WIDTH,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned AWID_VAL   = 1
) (
    input logic                ACLK,
    input logic                ARESETn,
    axi_store_buffer_if.slave  bus
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned OFF_W  = $clog2(STRB_WIDTH);
    localparam int unsigned WORD_W = ADDR_WIDTH - OFF_W;

    sb_entry_t        mem_q [DEPTH];
    sb_entry_t        new_entry;
    sb_entry_t        head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    sb_state_e        state_q, state_d;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             wen_c;
    logic             data_resp_c;

    logic [WORD_W-1:0] word_addr [DEPTH];
`ifdef STORE_BUF_FWD_EN
    logic [DATA_WIDTH-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0]      ent_full_mask;
`endif
    logic [OFF_W-1:0]  unused_ld_lo;
    logic              unused_writing;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    // Full blocks a push even when the head retires in the same cycle.
    assign push  = bus.st_req && !full;

    assign new_entry = '{addr: bus.st_addr, data: bus.st_wdata,
                         mask: bus.st_wmask, size: bus.st_size};
    assign head      = mem_q[rd_ptr_q];

    // Drain FSM next-state and request/response strobes.
    always_comb begin
        state_d     = state_q;
        wen_c       = 1'b0;
        data_resp_c = 1'b0;
        pop         = 1'b0;
        case (state_q)
            SB_ISSUE: begin
                wen_c = !empty;
                if (wen_c && bus.waddr_ok) begin
                    state_d = SB_WAIT_RESP;
                end
            end
            SB_WAIT_RESP: begin
                data_resp_c = 1'b1;
                if (bus.wdata_ok) begin
                    pop     = 1'b1;
                    state_d = SB_ISSUE;
                end
            end
            default: state_d = SB_ISSUE;
        endcase
    end

    // FIFO pointer and occupancy update.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q  <= SB_ISSUE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared on reset so idle data outputs read zero.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    // Per-slot views for the load comparator.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            word_addr[i] = mem_q[i].addr[ADDR_WIDTH-1:OFF_W];
`ifdef STORE_BUF_FWD_EN
            ent_data[i]      = mem_q[i].data;
            ent_full_mask[i] = &mem_q[i].mask;
`endif
        end
    end

    axi_store_buffer_match #(
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W),
        .WORD_W     (WORD_W),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_match (
        .ld_word_i   (bus.ld_addr[ADDR_WIDTH-1:OFF_W]),
        .word_addr_i (word_addr),
        .count_i     (count_q),
        .rd_ptr_i    (rd_ptr_q),
`ifdef STORE_BUF_FWD_EN
        .data_i      (ent_data),
        .full_mask_i (ent_full_mask),
        .fwd_valid_c (bus.fwd_valid),
        .fwd_data_c  (bus.fwd_data),
`endif
        .hit_c       (bus.ld_hit)
    );

    // Head entry is presented directly, so fields stay put until it retires.
    assign bus.wen       = wen_c;
    assign bus.data_resp = data_resp_c;
    assign bus.awaddr    = head.addr;
    assign bus.wdata     = head.data;
    assign bus.wmask     = head.mask;
    assign bus.awsize    = head.size;
    assign bus.awid      = ID_WIDTH'(AWID_VAL);
    assign bus.st_ready  = !full;
    assign bus.sb_empty  = empty && (state_q == SB_ISSUE);

    // Byte offset of the load address and master status are not needed.
    assign unused_ld_lo   = bus.ld_addr[OFF_W-1:0];
    assign unused_writing = bus.writing;

endmodule
